// File: rtl/fifo_fwft.sv
// fifo_fwft: single-clock first-word-fall-through FIFO with almost-full/almost-empty flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags and err_clear.
module fifo_fwft #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 8,
  parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
  parameter int AFULL_THRESH  = RAM_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter     TYPE          = "BLOCK"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clear,
`endif
  output logic [ADDR_WIDTH:0]   fifo_count
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(RAM_DEPTH - 1);
  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   stored;
  logic                  do_push, do_pop, load;
  assign empty        = !data_valid;
  assign full         = fifo_count == DEPTH_C;
  assign almost_full  = fifo_count >= AF_C;
  assign almost_empty = fifo_count <= AE_C;
  assign do_push      = push && !full;
  assign do_pop       = pop && data_valid;
  // entries sitting in the RAM behind the head register
  assign stored       = fifo_count - {{ADDR_WIDTH{1'b0}}, data_valid};
  assign load         = (!data_valid || do_pop) && stored != '0;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (load) begin
        data_out   <= mem[rd_ptr];
        rd_ptr     <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        data_valid <= 1'b1;
      end else if (do_pop) data_valid <= 1'b0;
      fifo_count <= fifo_count + {{ADDR_WIDTH{1'b0}}, do_push} - {{ADDR_WIDTH{1'b0}}, do_pop};
    end
  end
`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (push && full) ? 1'b1 : err_clear ? 1'b0 : overflow;
      underflow <= (pop && empty) ? 1'b1 : err_clear ? 1'b0 : underflow;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: table vectors, directed corner sequences and random traffic against a queue model.
module tb_fifo_fwft;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0, pop = 1'b0, err_clear = 1'b0;
  logic [63:0] data_in = '0;
  logic [63:0] data_out;
  logic        data_valid, empty, full, almost_full, almost_empty;
  logic [8:0]  fifo_count;
`ifdef FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif
  int total = 0, bad = 0;
  logic [63:0] q[$];
  bit          mvalid = 1'b0, ov = 1'b0, un = 1'b0;
  logic [63:0] mlast = '0;

  fifo_fwft dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .data_valid(data_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow), .err_clear(err_clear),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count", 64'(fifo_count), 64'(n));
    chk("valid", 64'(data_valid), 64'(mvalid));
    chk("empty", 64'(empty), 64'(!mvalid));
    chk("full", 64'(full), 64'(n == 256));
    chk("afull", 64'(almost_full), 64'(n >= 252));
    chk("aempty", 64'(almost_empty), 64'(n <= 4));
    chk("dout", data_out, mlast);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 64'(overflow), 64'(ov));
    chk("underflow", 64'(underflow), 64'(un));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    mvalid = 1'b0;
    mlast = '0;
    ov = 1'b0;
    un = 1'b0;
  endtask

  // Only entries already held before an edge can become visible at that edge.
  task automatic cycle(input bit p, input logic [63:0] d, input bit po, input bit ec);
    bit full_m, dp, dpo;
    int n_old;
    push = p; data_in = d; pop = po; err_clear = ec;
    @(posedge clk);
    full_m = q.size() == 256;
    dp = p && !full_m;
    dpo = po && mvalid;
    n_old = q.size() - (dpo ? 1 : 0);
    ov = (p && full_m) ? 1'b1 : ec ? 1'b0 : ov;
    un = (po && !mvalid) ? 1'b1 : ec ? 1'b0 : un;
    if (dpo) void'(q.pop_front());
    if (dp) q.push_back(d);
    mvalid = n_old > 0;
    if (mvalid) mlast = q[0];
    #1;
    push = 1'b0; pop = 1'b0; err_clear = 1'b0;
    check_all();
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || fifo_count != 0) && k < 600) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    chk("drain_count", 64'(fifo_count), 64'd0);
  endtask

  typedef struct {
    bit          p;
    logic [63:0] d;
    bit          po;
    int          cnt;
    bit          v;
    logic [63:0] dout;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic [63:0] nxt, head;
    int rate;
    tbl[0] = '{1'b1, 64'hA5, 1'b0, 1, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 64'h0,  1'b0, 1, 1'b1, 64'hA5};
    tbl[2] = '{1'b0, 64'h0,  1'b1, 0, 1'b0, 64'hA5};
    tbl[3] = '{1'b1, 64'h11, 1'b0, 1, 1'b0, 64'hA5};
    tbl[4] = '{1'b1, 64'h22, 1'b1, 2, 1'b1, 64'h11};
    tbl[5] = '{1'b1, 64'h33, 1'b1, 2, 1'b1, 64'h22};
    tbl[6] = '{1'b0, 64'h0,  1'b1, 1, 1'b1, 64'h33};
    tbl[7] = '{1'b0, 64'h0,  1'b1, 0, 1'b0, 64'h33};
    tbl[8] = '{1'b0, 64'h0,  1'b1, 0, 1'b0, 64'h33};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check_all();
    chk("rst_dout", data_out, 64'h0);
    chk("rst_empty", 64'(empty), 64'd1);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].p, tbl[i].d, tbl[i].po, 1'b0);
      chk($sformatf("tbl%0d_cnt", i), 64'(fifo_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 64'(data_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
    end

`ifdef FIFO_ERR_FLAGS_EN
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("uf_set", 64'(underflow), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("uf_clear", 64'(underflow), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("uf_set_wins", 64'(underflow), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 256; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    cycle(1'b1, 64'h1FF, 1'b0, 1'b0);
    chk("ovf_count", 64'(fifo_count), 64'd256);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 64'(overflow), 64'd1);
`endif
    chk("stream0", data_out, 64'd0);
    cycle(1'b1, 64'h1FF, 1'b1, 1'b0);
    chk("push_pop_full_count", 64'(fifo_count), 64'd255);
    for (int i = 1; i < 256; i++) begin
      chk("stream", data_out, 64'(i));
      chk("stream_valid", 64'(data_valid), 64'd1);
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("stream_end_empty", 64'(empty), 64'd1);
    chk("stream_end_count", 64'(fifo_count), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    nxt = 64'd1000;
    head = 64'd1000;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, nxt, 1'b0, 1'b0);
      nxt++;
    end
    for (int i = 0; i < 1000; i++) begin
      chk("wrap_data", data_out, head);
      cycle(1'b1, nxt, 1'b1, 1'b0);
      chk("wrap_count", 64'(fifo_count), 64'd10);
      nxt++;
      head++;
    end
    drain();

    for (int i = 0; i < 3000; i++) begin
      rate = (i / 400) % 3 == 0 ? 75 : (i / 400) % 3 == 1 ? 25 : 50;
      cycle($urandom_range(99) < rate, {$urandom, $urandom},
            $urandom_range(99) < 100 - rate, $urandom_range(19) == 0);
    end
    drain();

    for (int i = 0; i < 100; i++) cycle(1'b1, 64'(i + 7), 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_valid", 64'(data_valid), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_dout", data_out, 64'd0);
    chk("arst_aempty", 64'(almost_empty), 64'd1);
    check_all();
    @(posedge clk);
    #3 reset = 1'b0;
    cycle(1'b1, 64'h3C, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_first", data_out, 64'h3C);
    chk("post_rst_valid", 64'(data_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
